// File: rtl/mux_arb_pkg.sv
// Shared types for the two-source packet arbiter: FSM state encoding and
// source identifiers used as the mux select.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

endpackage

// File: rtl/mux2_w.sv
// Width-parameterised 2:1 select: y = sel ? b : a.
module mux2_w #(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux2_pkt_arbiter.sv
// Round-robin packet arbiter for two valid/ready/last sources feeding one
// registered output stream; a granted source keeps the path until its last beat.
module mux2_pkt_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             in1_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_sel,
  output logic             err_trunc
);

  localparam int CW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BEATS - 1);

  state_t          state_reg, state_next;
  logic            prio_reg, prio_next;
  logic [CW-1:0]   beat_cnt_reg, beat_cnt_next;

  logic            load_en;
  logic            grant;
  logic            rdy0, rdy1;
  logic            accept;
  logic            src_last;
  logic            cnt_max;
  logic            eff_last;
  logic [WIDTH-1:0] src_data;

  assign load_en = !out_valid || out_ready;

  always_comb begin
    grant = SRC0;
    rdy0  = 1'b0;
    rdy1  = 1'b0;
    case (state_reg)
      IDLE: begin
        grant = (in0_valid && in1_valid) ? prio_reg : in1_valid;
        rdy0  = load_en && in0_valid && (grant == SRC0);
        rdy1  = load_en && in1_valid && (grant == SRC1);
      end
      LOCK0: begin
        grant = SRC0;
        rdy0  = load_en && in0_valid;
      end
      LOCK1: begin
        grant = SRC1;
        rdy1  = load_en && in1_valid;
      end
      default: begin
        grant = SRC0;
      end
    endcase
  end

  // Readies are forced low while reset is held so no source sees a handshake.
  assign in0_ready = rdy0 && rst_n;
  assign in1_ready = rdy1 && rst_n;
  assign accept    = in0_ready || in1_ready;

  mux2_w #(
    .WIDTH(WIDTH + 1)
  ) u_sel (
    .sel(grant),
    .a  ({in0_last, in0_data}),
    .b  ({in1_last, in1_data}),
    .y  ({src_last, src_data})
  );

  assign cnt_max  = (beat_cnt_reg == CNT_LAST);
  assign eff_last = src_last || cnt_max;

  always_comb begin
    state_next    = state_reg;
    prio_next     = prio_reg;
    beat_cnt_next = beat_cnt_reg;
    if (accept) begin
      if (eff_last) begin
        state_next    = IDLE;
        beat_cnt_next = '0;
        prio_next     = !grant;
      end else begin
        state_next    = (grant == SRC1) ? LOCK1 : LOCK0;
        beat_cnt_next = beat_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      prio_reg     <= 1'b0;
      beat_cnt_reg <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
      out_sel      <= 1'b0;
      err_trunc    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      prio_reg     <= prio_next;
      beat_cnt_reg <= beat_cnt_next;
      err_trunc    <= accept && cnt_max && !src_last;
      if (load_en) begin
        out_valid <= accept;
        if (accept) begin
          out_data <= src_data;
          out_last <= eff_last;
          out_sel  <= grant;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux2_pkt_arbiter.sv
// Randomized bench for mux2_pkt_arbiter: a packet-level reference model predicts
// readies and output beats; a separate monitor pops expected beats as they leave.
module tb_mux2_pkt_arbiter;

  localparam int WIDTH     = 8;
  localparam int MAX_BEATS = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in0_valid, in0_last, in0_ready;
  logic [WIDTH-1:0] in0_data;
  logic             in1_valid, in1_last, in1_ready;
  logic [WIDTH-1:0] in1_data;
  logic             out_ready;
  logic             out_valid, out_last, out_sel, err_trunc;
  logic [WIDTH-1:0] out_data;

  always #5 clk = ~clk;

  mux2_pkt_arbiter #(
    .WIDTH    (WIDTH),
    .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in0_valid(in0_valid),
    .in0_data (in0_data),
    .in0_last (in0_last),
    .in0_ready(in0_ready),
    .in1_valid(in1_valid),
    .in1_data (in1_data),
    .in1_last (in1_last),
    .in1_ready(in1_ready),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_sel  (out_sel),
    .err_trunc(err_trunc)
  );

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
    logic             sel;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    n_beats = 0;

  // Source generators
  logic             sv[2];
  logic [WIDTH-1:0] sdat[2];
  logic             slast[2];
  int               rem[2];
  int               pv = 100;
  int               pr = 100;

  assign in0_valid = sv[0];
  assign in0_data  = sdat[0];
  assign in0_last  = slast[0];
  assign in1_valid = sv[1];
  assign in1_data  = sdat[1];
  assign in1_last  = slast[1];

  // Reference model state: packet owner (-1 = none), beats so far, priority
  int    m_owner = -1;
  int    m_cnt   = 0;
  logic  m_prio  = 1'b0;
  logic  m_ov    = 1'b0;
  logic  m_trunc = 1'b0;
  logic  acc0 = 1'b0, acc1 = 1'b0;
  int    g;
  logic  ld, sl, fl;
  int    nc;
  beat_t nb, pb;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check8(input string name, input logic [WIDTH-1:0] act,
                        input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: arbitration rules applied to whole packets
  always @(negedge clk) begin
    if (!rst_n) begin
      m_owner = -1;
      m_cnt   = 0;
      m_prio  = 1'b0;
      m_ov    = 1'b0;
      m_trunc = 1'b0;
      acc0    = 1'b0;
      acc1    = 1'b0;
      exp_q.delete();
      check1("rst_ready0", in0_ready, 1'b0);
      check1("rst_ready1", in1_ready, 1'b0);
      check1("rst_out_valid", out_valid, 1'b0);
    end else begin
      check1("out_valid", out_valid, m_ov);
      check1("err_trunc", err_trunc, m_trunc);
      ld = !m_ov || out_ready;
      g  = -1;
      if (m_owner < 0) begin
        if (in0_valid && in1_valid) g = int'(m_prio);
        else if (in1_valid)         g = 1;
        else if (in0_valid)         g = 0;
      end else if ((m_owner == 0 && in0_valid) || (m_owner == 1 && in1_valid)) begin
        g = m_owner;
      end
      if (!ld) g = -1;
      check1("in0_ready", in0_ready, g == 0);
      check1("in1_ready", in1_ready, g == 1);
      acc0    = (g == 0);
      acc1    = (g == 1);
      m_trunc = 1'b0;
      if (g >= 0) begin
        sl      = (g == 1) ? in1_last : in0_last;
        nc      = m_cnt + 1;
        fl      = (nc == MAX_BEATS);
        nb.data = (g == 1) ? in1_data : in0_data;
        nb.last = sl || fl;
        nb.sel  = (g == 1);
        exp_q.push_back(nb);
        m_trunc = fl && !sl;
        if (sl || fl) begin
          m_owner = -1;
          m_cnt   = 0;
          m_prio  = (g == 0);
        end else begin
          m_owner = g;
          m_cnt   = nc;
        end
      end
      if (ld) m_ov = (g >= 0);
    end
  end

  // Monitor: compares each beat as it is consumed downstream
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data %02h, expected no beat", out_data);
      end else begin
        pb = exp_q.pop_front();
        check8("out_data", out_data, pb.data);
        check1("out_last", out_last, pb.last);
        check1("out_sel", out_sel, pb.sel);
        n_beats++;
        $display("beat %0d: sel=%0b data=%02h last=%0b", n_beats, out_sel, out_data, out_last);
      end
    end
  end

  task automatic new_beat(input int k);
    if (rem[k] == 0) rem[k] = int'($urandom_range(1, 6));
    sdat[k]  = WIDTH'($urandom);
    slast[k] = (rem[k] == 1);
    sv[k]    = 1'b1;
  endtask

  task automatic step_sources();
    for (int k = 0; k < 2; k++) begin
      if ((k == 0 && acc0) || (k == 1 && acc1)) begin
        rem[k]--;
        sv[k] = 1'b0;
      end
      if (!sv[k] && int'($urandom_range(0, 99)) < pv) new_beat(k);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      step_sources();
      out_ready = (int'($urandom_range(0, 99)) < pr);
    end
  endtask

  task automatic fresh_sources();
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0;
      new_beat(k);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check1({tag, "_out_valid"}, out_valid, 1'b0);
    check8({tag, "_out_data"}, out_data, '0);
    check1({tag, "_out_last"}, out_last, 1'b0);
    check1({tag, "_out_sel"}, out_sel, 1'b0);
    check1({tag, "_err_trunc"}, err_trunc, 1'b0);
    check1({tag, "_in0_ready"}, in0_ready, 1'b0);
    check1({tag, "_in1_ready"}, in1_ready, 1'b0);
  endtask

  int waited;

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    sv[0] = 1'b0; sv[1] = 1'b0;
    fresh_sources();
    repeat (3) @(posedge clk);
    #2;
    check_outputs_zero("reset");

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check1("first_grant_in0", in0_ready, 1'b1);
    check1("first_grant_in1", in1_ready, 1'b0);

    pv = 100; pr = 100; run(40);
    pv = 70;  pr = 60;  run(300);
    pv = 100; pr = 30;  run(200);

    // Reset in the middle of a source-1 packet
    pv = 80; pr = 80;
    waited = 0;
    while (m_owner != 1 && waited < 2000) begin
      run(1);
      waited++;
    end
    check1("lock1_reached", waited < 2000, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    fresh_sources();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check1("tie_after_reset_in0", in0_ready, 1'b1);
    check1("tie_after_reset_in1", in1_ready, 1'b0);

    pv = 100; pr = 100; run(100);
    pv = 60;  pr = 70;  run(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
